prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
Boot-time writer for the instruction store that the datapath fetches from. It accepts a byte stream through a valid/ready handshake, for example from a UART receiver. It assembles the bytes into 16-bit instruction words, writes them to consecutive word-aligned program-memory addresses, and then releases the CPU to run. It is the write-side counterpart of the datapath's instruction fetch port, which is read-only, PC-addressed and steps by 2.

Parameters:
BASE_ADDR, 16'h0000, byte address of the first instruction written; must be even.
MAX_WORDS, 256, largest accepted word count; a header above this goes to ERR.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
restart  in  1  one-cycle pulse; rearms the loader from DONE or ERR
pm_we  out  1  program-memory write strobe, one cycle per word
pm_addr  out  16  program-memory byte address (always even)
pm_wdata  out  16  instruction word
cpu_run  out  1  high = CPU may fetch; low holds CPU (PC held at reset)
busy  out  1  high from first header byte accepted until DONE/ERR
err  out  1  sticky error flag
words_loaded  out  16  words written so far

Behaviour:
- Reset: all outputs 0, pm_addr = BASE_ADDR, state HDR_HI. Reset mid-load aborts immediately; no further pm_we; partial words are discarded.
- Byte transfer: a byte is accepted in a cycle where in_valid & in_ready. in_ready is high only in HDR_HI, HDR_LO, DAT_HI, DAT_LO (and CHK when enabled); it is low in DONE and ERR.
- Stream format: 2-byte word count N, high byte first; then N words, each high byte first.
- HDR_HI: on accept, latch count[15:8], set busy, go to HDR_LO.
- HDR_LO: on accept, latch count[7:0].
  - N > MAX_WORDS: go to ERR.
  - N = 0: go to DONE (or to CHK when the optional feature is compiled in).
  - Otherwise: go to DAT_HI.
- DAT_HI: on accept, latch the high byte, go to DAT_LO.
- DAT_LO: on accept, go to the next state.
  - The next cycle has pm_we = 1, pm_wdata = {hi, lo}, pm_addr = BASE_ADDR + 2*words_loaded.
  - The same edge that deasserts pm_we increments words_loaded.
  - Write latency: exactly 1 cycle after the low-byte accept.
  - After the last word, go to DONE (or CHK); otherwise go back to DAT_HI. Back-to-back bytes with no stall are supported.
- Address arithmetic: 16-bit; wrap at 16'hFFFE -> 16'h0000 is permitted and not flagged.
- DONE: cpu_run = 1, busy = 0, in_ready = 0.
- ERR: err = 1, cpu_run = 0, busy = 0, in_ready = 0; pm_we is never asserted.
- restart in DONE or ERR: next cycle cpu_run = 0, err = 0, words_loaded = 0, pm_addr = BASE_ADDR, state HDR_HI.
- restart in any other state: ignored.
- restart in the same cycle as a byte accept: the byte is processed normally and restart is ignored.
- in_data is sampled only on accept; in_valid deasserting mid-word simply waits, with no timeout.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or the header when N = 0), the state CHK expects one trailing byte.
  - The expected value is the 8-bit modulo-256 sum of every preceding byte, header included.
  - Match: go to DONE.
  - Mismatch: go to ERR and set err. Words already written remain in memory, but cpu_run stays 0.
- Not defined:
  - No CHK state; the stream ends after the last word and the FSM goes directly to DONE.
  - Any extra byte sees in_ready = 0.

Test Plan:
- Load 2 words: bytes 00 02 12 34 AB CD -> pm_we pulses at 0x0000 = 0x1234 and 0x0002 = 0xABCD, each 1 cycle after its low-byte accept; words_loaded = 2; cpu_run rises; in_ready = 0 afterwards.
- Zero length: bytes 00 00 -> no pm_we, cpu_run = 1 (checksum build: also needs trailing 00).
- Oversize: header 01 01 (257) with MAX_WORDS = 256 -> err = 1, in_ready = 0, no pm_we, cpu_run = 0. restart pulse -> err = 0 and the loader accepts a new header.
- Stall and back-pressure: in_valid toggled randomly during 3 words -> data/address identical to the unstalled run; exactly 3 pm_we pulses.
- Reset mid-load: assert rst after the high byte of word 2 of a 4-word load -> all outputs 0 immediately. A fresh 1-word stream after reset writes at BASE_ADDR.
- LOADER_CHECKSUM_EN: 00 01 12 34 47 -> DONE. The same stream with trailer 48 -> err = 1, cpu_run = 0, while 0x1234 is still written at 0x0000.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: boot-time writer for the instruction store.
// Takes a valid/ready byte stream of the form {count_hi, count_lo, N x {hi, lo}}.
// It writes each 16-bit word to consecutive even addresses starting at BASE_ADDR.
// When the load completes it raises cpu_run.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, the stream carries one
// trailing byte equal to the modulo-256 sum of all preceding bytes, and that byte
// is checked in the CHK state before the CPU is released.
module prog_mem_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        restart,
    output logic        pm_we,
    output logic [15:0] pm_addr,
    output logic [15:0] pm_wdata,
    output logic        cpu_run,
    output logic        busy,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DAT_HI = 3'd2;
    localparam logic [2:0] S_DAT_LO = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd6;
    localparam logic [2:0] S_TAIL   = S_CHK;
`else
    localparam logic [2:0] S_TAIL   = S_DONE;
`endif

    // States in which a stream byte may be accepted.
    function automatic logic f_takes_bytes(input logic [2:0] st);
        logic v;
        case (st)
            S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO: v = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                                  v = 1'b1;
`endif
            default:                                v = 1'b0;
        endcase
        return v;
    endfunction

    // States between the first header byte and DONE/ERR.
    function automatic logic f_is_busy(input logic [2:0] st);
        logic v;
        case (st)
            S_HDR_LO, S_DAT_HI, S_DAT_LO: v = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                        v = 1'b1;
`endif
            default:                      v = 1'b0;
        endcase
        return v;
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_ready;
    logic        r_busy;
    logic        r_run;
    logic        r_err;
    logic        r_we;
    logic [15:0] r_wdata;
    logic [15:0] r_addr;
    logic [15:0] r_words;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_left;
    logic [7:0]  r_hi;
    logic        w_accept;
    logic        w_rearm;
    logic [15:0] w_hdr_count;
    logic        w_too_big;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    assign w_accept    = in_valid & r_ready;
    assign w_rearm     = restart & ((r_state == S_DONE) | (r_state == S_ERR));
    assign w_hdr_count = {r_cnt_hi, in_data};
    assign w_too_big   = ({16'h0000, w_hdr_count} > MAX_WORDS);

    assign in_ready     = r_ready;
    assign pm_we        = r_we;
    assign pm_addr      = r_addr;
    assign pm_wdata     = r_wdata;
    assign cpu_run      = r_run;
    assign busy         = r_busy;
    assign err          = r_err;
    assign words_loaded = r_words;

    // Next-state decode for the load sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR_HI: begin
                if (w_accept) w_state_nxt = S_HDR_LO;
                else          w_state_nxt = r_state;
            end
            S_HDR_LO: begin
                if (!w_accept)                   w_state_nxt = r_state;
                else if (w_too_big)              w_state_nxt = S_ERR;
                else if (w_hdr_count == 16'd0)   w_state_nxt = S_TAIL;
                else                             w_state_nxt = S_DAT_HI;
            end
            S_DAT_HI: begin
                if (w_accept) w_state_nxt = S_DAT_LO;
                else          w_state_nxt = r_state;
            end
            S_DAT_LO: begin
                if (!w_accept)             w_state_nxt = r_state;
                else if (r_left == 16'd1)  w_state_nxt = S_TAIL;
                else                       w_state_nxt = S_DAT_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (!w_accept)             w_state_nxt = r_state;
                else if (in_data == r_sum) w_state_nxt = S_DONE;
                else                       w_state_nxt = S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (w_rearm) w_state_nxt = S_HDR_HI;
                else         w_state_nxt = r_state;
            end
            default: w_state_nxt = S_HDR_HI;
        endcase
    end

    // State, registered status outputs, word assembly and write-address tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_HDR_HI;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= 16'h0000;
            r_addr   <= BASE_ADDR;
            r_words  <= 16'h0000;
            r_cnt_hi <= 8'h00;
            r_left   <= 16'h0000;
            r_hi     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= f_takes_bytes(w_state_nxt);
            r_busy  <= f_is_busy(w_state_nxt);
            r_run   <= (w_state_nxt == S_DONE);
            r_err   <= (w_state_nxt == S_ERR);
            // The write strobe is a single-cycle pulse following each low-byte accept.
            r_we    <= w_accept & (r_state == S_DAT_LO);
            if (w_accept) begin
                case (r_state)
                    S_HDR_HI: r_cnt_hi <= in_data;
                    S_HDR_LO: r_left   <= w_hdr_count;
                    S_DAT_HI: r_hi     <= in_data;
                    S_DAT_LO: begin
                        r_wdata <= {r_hi, in_data};
                        r_left  <= r_left - 16'd1;
                    end
                    default: r_hi <= r_hi;
                endcase
            end
            // The address and the count advance as the write strobe drops, so
            // pm_addr equals BASE_ADDR + 2*words_loaded while pm_we is high.
            if (w_rearm) begin
                r_words <= 16'h0000;
                r_addr  <= BASE_ADDR;
            end else if (r_we) begin
                r_words <= r_words + 16'd1;
                r_addr  <= r_addr + 16'd2;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running modulo-256 sum of every byte that precedes the checksum trailer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= 8'h00;
        end else if (w_rearm) begin
            r_sum <= 8'h00;
        end else if (w_accept && (r_state != S_CHK)) begin
            r_sum <= r_sum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: table-driven streams plus hand sequences
// for stalls, mid-load reset, the MAX_WORDS boundary and the checksum trailer.
module tb_prog_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        pm_we;
    logic [15:0] pm_addr;
    logic [15:0] pm_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -10;
    int nw = 0;
    logic [15:0] log_addr [0:299];
    logic [15:0] log_data [0:299];
    logic [7:0]  csum;

    typedef struct {
        string       name;
        int          nbytes;
        logic [63:0] bytes;
        int          nwr;
        logic [63:0] wdata;
        logic        run;
        logic        er;
        logic [15:0] words;
    } vec_t;

    vec_t vecs[4];
    vec_t vstall;

    prog_mem_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .restart(restart), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write logger: checks each pm_we pulse lands exactly one cycle after the last accept.
    always begin
        @(negedge clk);
        #2;
        if (pm_we) begin
            checks++;
            if (cyc != last_acc) begin
                errors++;
                $display("FAIL wr_latency: write in cycle %0d, required cycle %0d", cyc, last_acc);
            end
            if (nw < 300) begin
                log_addr[nw] = pm_addr;
                log_data[nw] = pm_wdata;
            end
            nw++;
        end
        if (in_valid && in_ready && !rst) last_acc = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        int n;
        if (stall) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        csum     = csum + b;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready %0b for byte %h, required 1", in_ready, b);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit stall);
        csum = 8'h00;
        nw   = 0;
        for (int i = 0; i < v.nbytes; i++) send(v.bytes[63 - 8*i -: 8], stall);
`ifdef LOADER_CHECKSUM_EN
        if (!v.er) send(csum, stall);
`endif
        repeat (3) @(negedge clk);
        chk({v.name, "_nwr"}, 32'(nw), 32'(v.nwr));
        for (int i = 0; i < v.nwr && i < 4; i++) begin
            chk({v.name, "_addr"}, 32'(log_addr[i]), 32'(16'(2 * i)));
            chk({v.name, "_data"}, 32'(log_data[i]), 32'(v.wdata[63 - 16*i -: 16]));
        end
        chk({v.name, "_run"},   32'(cpu_run), 32'(v.run));
        chk({v.name, "_err"},   32'(err), 32'(v.er));
        chk({v.name, "_busy"},  32'(busy), 32'd0);
        chk({v.name, "_ready"}, 32'(in_ready), 32'd0);
        chk({v.name, "_words"}, 32'(words_loaded), 32'(v.words));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_run",   32'(cpu_run), 32'd0);
        chk("rs_err",   32'(err), 32'd0);
        chk("rs_words", 32'(words_loaded), 32'd0);
        chk("rs_addr",  32'(pm_addr), 32'h0000);
        chk("rs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"two",  6, 64'h0002_1234_ABCD_0000, 2, 64'h1234_ABCD_0000_0000, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{"zero", 2, 64'h0000_0000_0000_0000, 0, 64'h0,                   1'b1, 1'b0, 16'd0};
        vecs[2] = '{"over", 2, 64'h0101_0000_0000_0000, 0, 64'h0,                   1'b0, 1'b1, 16'd0};
        vecs[3] = '{"one",  4, 64'h0001_BEEF_0000_0000, 1, 64'hBEEF_0000_0000_0000, 1'b1, 1'b0, 16'd1};
        vstall  = '{"stall", 8, 64'h0003_1122_3344_5566, 3, 64'h1122_3344_5566_0000, 1'b1, 1'b0, 16'd3};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0; csum = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_we",    32'(pm_we), 32'd0);
        chk("rst_addr",  32'(pm_addr), 32'h0000);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_run",   32'(cpu_run), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k], 1'b0);
            do_restart();
        end

        run_vec(vstall, 1'b1);
        do_restart();

        // Reset after the high byte of word 2 of a 4-word load.
        csum = 8'h00;
        nw   = 0;
        send(8'h00, 1'b0); send(8'h04, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hB1, 1'b0);
        chk("mid_words", 32'(words_loaded), 32'd1);
        chk("mid_first", 32'(log_data[0]), 32'h0000_A1A2);
        rst = 1'b1;
        #1;
        chk("arst_we",    32'(pm_we), 32'd0);
        chk("arst_addr",  32'(pm_addr), 32'h0000);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        nw = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        csum = 8'h00;
        send(8'h00, 1'b0); send(8'h01, 1'b0);
        restart = 1'b1;
        send(8'h5A, 1'b0);
        restart = 1'b0;
        send(8'h3C, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send(csum, 1'b0);
`endif
        repeat (3) @(negedge clk);
        chk("fresh_nwr",  32'(nw), 32'd1);
        chk("fresh_addr", 32'(log_addr[0]), 32'h0000);
        chk("fresh_data", 32'(log_data[0]), 32'h0000_5A3C);
        chk("fresh_run",  32'(cpu_run), 32'd1);
        do_restart();

        // Largest accepted count: 256 words, last one at 0x01FE.
        csum = 8'h00;
        nw   = 0;
        send(8'h01, 1'b0); send(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 1'b0);
            send(~8'(i), 1'b0);
        end
`ifdef LOADER_CHECKSUM_EN
        send(csum, 1'b0);
`endif
        repeat (3) @(negedge clk);
        chk("max_nwr",   32'(nw), 32'd256);
        chk("max_d0",    32'(log_data[0]), 32'h0000_00FF);
        chk("max_alast", 32'(log_addr[255]), 32'h0000_01FE);
        chk("max_dlast", 32'(log_data[255]), 32'h0000_FF00);
        chk("max_words", 32'(words_loaded), 32'h0000_0100);
        chk("max_run",   32'(cpu_run), 32'd1);
        do_restart();

`ifdef LOADER_CHECKSUM_EN
        // Checksum trailer: 0x47 matches, 0x48 does not.
        nw = 0;
        send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h47, 1'b0);
        repeat (3) @(negedge clk);
        chk("cs_ok_run", 32'(cpu_run), 32'd1);
        chk("cs_ok_err", 32'(err), 32'd0);
        do_restart();
        nw = 0;
        send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h48, 1'b0);
        repeat (3) @(negedge clk);
        chk("cs_bad_err",  32'(err), 32'd1);
        chk("cs_bad_run",  32'(cpu_run), 32'd0);
        chk("cs_bad_nwr",  32'(nw), 32'd1);
        chk("cs_bad_addr", 32'(log_addr[0]), 32'h0000);
        chk("cs_bad_data", 32'(log_data[0]), 32'h0000_1234);
        do_restart();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
